// File: rtl/axi_pkg.sv
// Shared AXI4-Lite memory definitions: response codes, channel FSM states,
// and the delay LFSR polynomial (x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form).
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Feedback taps on bits 7,5,4,3 of the 8-bit state.
    localparam logic [7:0] LFSR_TAP = 8'hB8;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // One LFSR step: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAP)};
    endfunction

endpackage

// File: rtl/lfsr_delay.sv
// Per-channel response delay source.
// Ports: clk, rst (async active-low), dly = delay to load at the current cycle.
// The LFSR free-runs every cycle from its seed; in fixed mode dly is constant.
module lfsr_delay
    import axi_pkg::*;
#(
    parameter logic [7:0]  SEED  = 8'hA5,
    parameter int unsigned DLY_W = 4,
    parameter bit          RAND  = 1'b1,
    parameter int unsigned FIX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [DLY_W-1:0] dly
);

    logic [7:0] lfsr_q;

    // Free-running LFSR state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_next(lfsr_q);
    end

    if (RAND) begin : g_rand
        assign dly = lfsr_q[DLY_W-1:0];
    end else begin : g_fix
        assign dly = DLY_W'(FIX);
    end

endmodule

// File: rtl/axi_lite_mem.sv
// AXI4-Lite slave memory with byte strobes and per-channel programmable latency.
// Ports: clk, rst (async active-low); AR/R read channels (araddr, arvalid,
// arready, rdata, rresp, rvalid, rready); AW/W/B write channels (awaddr,
// awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready).
// Words beyond DEPTH answer SLVERR, read as zero and are never written.
module axi_lite_mem
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned RAND_DLY = 1,
    parameter int unsigned FIX_DLY  = 0,
    parameter int unsigned DLY_W    = 4,
    parameter logic [7:0]  SEED_R   = 8'hA5,
    parameter logic [7:0]  SEED_W   = 8'h3C
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned WORD_W = ADDR_W - OFF_W;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Word decode; byte-offset bits are deliberately ignored.
    logic [WORD_W-1:0] ar_word, aw_word;
    logic              ar_ok_c, aw_ok_c;
    logic              unused_addr_lsb;
    assign ar_word         = araddr[ADDR_W-1:OFF_W];
    assign aw_word         = awaddr[ADDR_W-1:OFF_W];
    assign ar_ok_c         = 64'(ar_word) < 64'(DEPTH);
    assign aw_ok_c         = 64'(aw_word) < 64'(DEPTH);
    assign unused_addr_lsb = ^{araddr[OFF_W-1:0], awaddr[OFF_W-1:0]};

    logic [DLY_W-1:0] rd_dly, wr_dly;

    lfsr_delay #(.SEED(SEED_R), .DLY_W(DLY_W), .RAND(RAND_DLY != 0), .FIX(FIX_DLY)) u_rd_dly (
        .clk (clk),
        .rst (rst),
        .dly (rd_dly)
    );

    lfsr_delay #(.SEED(SEED_W), .DLY_W(DLY_W), .RAND(RAND_DLY != 0), .FIX(FIX_DLY)) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .dly (wr_dly)
    );

    // ---------------- read channel ----------------
    rd_state_t         rd_state_q, rd_state_d;
    logic [DLY_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;
    logic              rd_ok_q, rd_ok_d;
    logic [DATA_W-1:0] rdata_d;
    logic [1:0]        rresp_d;
    logic              rvalid_d, arready_d;

    // Read state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            rd_idx_q   <= '0;
            rd_ok_q    <= 1'b0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
            rvalid     <= 1'b0;
            arready    <= 1'b1;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_idx_q   <= rd_idx_d;
            rd_ok_q    <= rd_ok_d;
            rdata      <= rdata_d;
            rresp      <= rresp_d;
            rvalid     <= rvalid_d;
            arready    <= arready_d;
        end
    end

    // Read next-state: capture, count down, then hold the response until taken.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_idx_d   = rd_idx_q;
        rd_ok_d    = rd_ok_q;
        rdata_d    = rdata;
        rresp_d    = rresp;
        rvalid_d   = rvalid;
        arready_d  = arready;
        case (rd_state_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    rd_idx_d   = MEM_AW'(ar_word);
                    rd_ok_d    = ar_ok_c;
                    rd_cnt_d   = rd_dly;
                    arready_d  = 1'b0;
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == '0) begin
                    // Non-blocking memory update means a same-cycle write is not yet visible.
                    rdata_d    = rd_ok_q ? mem[rd_idx_q] : '0;
                    rresp_d    = rd_ok_q ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: begin
                rvalid_d   = 1'b0;
                arready_d  = 1'b1;
                rd_state_d = R_IDLE;
            end
        endcase
    end

    // ---------------- write channel ----------------
    wr_state_t         wr_state_q, wr_state_d;
    logic [DLY_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
    logic              wr_ok_q, wr_ok_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic              awready_d, wready_d, bvalid_d;
    logic [1:0]        bresp_d;
    logic              aw_hs_c, w_hs_c, wr_commit_c;

    assign aw_hs_c = awvalid && awready;
    assign w_hs_c  = wvalid && wready;

    // Write state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            wr_idx_q   <= '0;
            wr_ok_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awready    <= 1'b1;
            wready     <= 1'b1;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_idx_q   <= wr_idx_d;
            wr_ok_q    <= wr_ok_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_got_q   <= aw_got_d;
            w_got_q    <= w_got_d;
            awready    <= awready_d;
            wready     <= wready_d;
            bvalid     <= bvalid_d;
            bresp      <= bresp_d;
        end
    end

    // Write next-state: AW and W captured independently, delay starts once both are held.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_cnt_d    = wr_cnt_q;
        wr_idx_d    = wr_idx_q;
        wr_ok_d     = wr_ok_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        awready_d   = awready;
        wready_d    = wready;
        bvalid_d    = bvalid;
        bresp_d     = bresp;
        wr_commit_c = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    wr_idx_d  = MEM_AW'(aw_word);
                    wr_ok_d   = aw_ok_c;
                    aw_got_d  = 1'b1;
                    awready_d = 1'b0;
                end
                if (w_hs_c) begin
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                    w_got_d  = 1'b1;
                    wready_d = 1'b0;
                end
                if ((aw_got_q || aw_hs_c) && (w_got_q || w_hs_c)) begin
                    aw_got_d   = 1'b0;
                    w_got_d    = 1'b0;
                    wr_cnt_d   = wr_dly;
                    wr_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == '0) begin
                    wr_commit_c = wr_ok_q;
                    bresp_d     = wr_ok_q ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d    = 1'b1;
                    wr_state_d  = W_RESP;
                end else begin
                    wr_cnt_d = wr_cnt_q - 1'b1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
                aw_got_d   = 1'b0;
                w_got_d    = 1'b0;
                bvalid_d   = 1'b0;
                awready_d  = 1'b1;
                wready_d   = 1'b1;
                wr_state_d = W_IDLE;
            end
        endcase
    end

    // Strobed memory commit; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_commit_c) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) mem[wr_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mem.sv
// Bench for axi_lite_mem: instance 0 uses fixed zero latency, instance 1 uses
// LFSR latency. A word-array reference memory and an LFSR sequence computed
// from the polynomial predict data, responses and latencies.
module tb_axi_lite_mem;

    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] araddr [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata [2];
    logic [1:0]  rresp [2];
    logic        rvalid [2];
    logic        rready [2];
    logic [31:0] awaddr [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        wvalid [2];
    logic        wready [2];
    logic [1:0]  bresp [2];
    logic        bvalid [2];
    logic        bready [2];

    int total = 0;
    int bad   = 0;
    int cyc;
    logic [31:0] ref_mem [2][DEPTH];

    axi_lite_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RAND_DLY(0), .FIX_DLY(0),
                   .DLY_W(4), .SEED_R(8'hA5), .SEED_W(8'h3C)) u_fix (
        .clk(clk), .rst(rst),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
    );

    axi_lite_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RAND_DLY(1), .FIX_DLY(0),
                   .DLY_W(4), .SEED_R(8'hA5), .SEED_W(8'h3C)) u_rnd (
        .clk(clk), .rst(rst),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
    );

    // Clock edges seen since reset release = LFSR steps taken.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Delay the next handshake edge will load: low 4 bits of the seed stepped cyc times.
    function automatic int pred_dly(input int k, input bit wr);
        logic [7:0] s;
        if (k == 0) return 0;
        s = wr ? 8'h3C : 8'hA5;
        for (int i = 0; i < cyc; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return int'(s[3:0]);
    endfunction

    function automatic bit in_range(input logic [31:0] addr);
        return (addr >> 2) < DEPTH;
    endfunction

    task automatic do_read(input int k, input logic [31:0] addr, input int stall);
        int d, n;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        exp_d = in_range(addr) ? ref_mem[k][addr >> 2] : 32'h0;
        exp_r = in_range(addr) ? 2'b00 : 2'b10;
        chk("arready_idle", 32'(arready[k]), 32'd1);
        d = pred_dly(k, 1'b0);
        araddr[k]  = addr;
        arvalid[k] = 1'b1;
        rready[k]  = 1'b0;
        @(posedge clk); #1;
        arvalid[k] = 1'b0;
        n = 0;
        while (rvalid[k] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_latency", 32'(n), 32'(d + 1));
        chk("rdata", rdata[k], exp_d);
        chk("rresp", 32'(rresp[k]), 32'(exp_r));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("rvalid_stall", 32'(rvalid[k]), 32'd1);
            chk("rdata_stall", rdata[k], exp_d);
        end
        rready[k] = 1'b1;
        @(posedge clk); #1;
        rready[k] = 1'b0;
        chk("rvalid_drop", 32'(rvalid[k]), 32'd0);
        chk("arready_back", 32'(arready[k]), 32'd1);
    endtask

    // lead > 0: AW goes lead cycles before W; lead < 0: W goes first; 0: together.
    task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
        int d, n;
        chk("awready_idle", 32'(awready[k]), 32'd1);
        chk("wready_idle", 32'(wready[k]), 32'd1);
        awaddr[k] = addr;
        wdata[k]  = data;
        wstrb[k]  = strb;
        bready[k] = 1'b0;
        d = 0;
        if (lead > 0) begin
            awvalid[k] = 1'b1;
            @(posedge clk); #1;
            awvalid[k] = 1'b0;
            chk("aw_first_awready", 32'(awready[k]), 32'd0);
            chk("aw_first_wready", 32'(wready[k]), 32'd1);
            repeat (lead - 1) begin @(posedge clk); #1; end
            d = pred_dly(k, 1'b1);
            wvalid[k] = 1'b1;
            @(posedge clk); #1;
            wvalid[k] = 1'b0;
        end else if (lead < 0) begin
            wvalid[k] = 1'b1;
            @(posedge clk); #1;
            wvalid[k] = 1'b0;
            chk("w_first_wready", 32'(wready[k]), 32'd0);
            chk("w_first_awready", 32'(awready[k]), 32'd1);
            repeat (-lead - 1) begin @(posedge clk); #1; end
            d = pred_dly(k, 1'b1);
            awvalid[k] = 1'b1;
            @(posedge clk); #1;
            awvalid[k] = 1'b0;
        end else begin
            d = pred_dly(k, 1'b1);
            awvalid[k] = 1'b1;
            wvalid[k]  = 1'b1;
            @(posedge clk); #1;
            awvalid[k] = 1'b0;
            wvalid[k]  = 1'b0;
        end
        n = 0;
        while (bvalid[k] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_latency", 32'(n), 32'(d + 1));
        chk("bresp", 32'(bresp[k]), in_range(addr) ? 32'd0 : 32'd2);
        if (in_range(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[k][addr >> 2][8*b +: 8] = data[8*b +: 8];
        end
        bready[k] = 1'b1;
        @(posedge clk); #1;
        bready[k] = 1'b0;
        chk("bvalid_drop", 32'(bvalid[k]), 32'd0);
        chk("awready_back", 32'(awready[k]), 32'd1);
        chk("wready_back", 32'(wready[k]), 32'd1);
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk({tag, "_arready"}, 32'(arready[k]), 32'd1);
        chk({tag, "_awready"}, 32'(awready[k]), 32'd1);
        chk({tag, "_wready"}, 32'(wready[k]), 32'd1);
        chk({tag, "_rvalid"}, 32'(rvalid[k]), 32'd0);
        chk({tag, "_bvalid"}, 32'(bvalid[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, old;
        for (int k = 0; k < 2; k++) begin
            araddr[k] = '0; arvalid[k] = 1'b0; rready[k] = 1'b0;
            awaddr[k] = '0; awvalid[k] = 1'b0; wdata[k]  = '0;
            wstrb[k]  = '0; wvalid[k]  = 1'b0; bready[k] = 1'b0;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk_idle(k, "reset");
            chk("reset_rdata", rdata[k], 32'h0);
            chk("reset_rresp", 32'(rresp[k]), 32'd0);
            chk("reset_bresp", 32'(bresp[k]), 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Preload every word of both memories.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                do_write(k, 32'(i * 4), $urandom, 4'hF, 0);

        // Zero-latency write/read and byte strobe merge.
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_read(0, 32'h10, 0);
        do_write(0, 32'h10, 32'h000000AA, 4'b0001, 0);
        do_read(0, 32'h10, 0);
        chk("strobe_model", ref_mem[0][4], 32'hDEADBEAA);

        // AW/W ordering on both instances.
        for (int k = 0; k < 2; k++) begin
            do_write(k, 32'h14, $urandom, 4'hF, 3);
            do_read(k, 32'h14, 0);
            do_write(k, 32'h18, $urandom, 4'hF, -3);
            do_read(k, 32'h18, 0);
        end

        // Out-of-range index: SLVERR, zero data, word 0 untouched by aliasing.
        for (int k = 0; k < 2; k++) begin
            do_read(k, 32'(DEPTH * 4), 0);
            do_write(k, 32'(DEPTH * 4), 32'h12345678, 4'hF, 0);
            do_read(k, 32'h0, 0);
        end

        // Unaligned addresses resolve to the containing word.
        do_read(0, 32'h13, 0);
        do_write(1, 32'h22, 32'hCAFEF00D, 4'b1010, 1);
        do_read(1, 32'h21, 1);

        // Same-cycle read and write commit to one word: read sees old data.
        fork
            do_read(0, 32'h20, 0);
            do_write(0, 32'h20, 32'h5A5A1234, 4'hF, 0);
        join
        do_read(0, 32'h20, 0);

        // Back-to-back random-latency reads, each stalled two cycles.
        for (int i = 0; i < 20; i++)
            do_read(1, 32'($urandom_range(0, DEPTH - 1) * 4), 2);

        // Random strobed writes with random channel ordering.
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
            do_write(i % 2, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2);
            do_read(i % 2, a, 0);
        end

        // Reset while both channels of instance 1 are counting down.
        a   = 32'h40;
        old = ref_mem[1][16];
        araddr[1] = a; arvalid[1] = 1'b1;
        awaddr[1] = a; awvalid[1] = 1'b1;
        wdata[1]  = ~old; wstrb[1] = 4'hF; wvalid[1] = 1'b1;
        @(posedge clk); #1;
        arvalid[1] = 1'b0; awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_rvalid", 32'(rvalid[1]), 32'd0);
        chk("rst_bvalid", 32'(bvalid[1]), 32'd0);
        chk("rst_rdata", rdata[1], 32'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk_idle(1, "post_rst");
        do_read(1, a, 0);
        chk("rst_word_model", ref_mem[1][16], old);
        do_read(0, 32'h10, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
